// File: rtl/tt_response_checker.sv
// tt_response_checker: sweeps every input combination of a small combinational
// block in ascending order, holds each vector for a programmable settle time,
// samples the block's output on the last cycle of that window and judges it
// against a truth table captured when the sweep starts.
module tt_response_checker #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  localparam int TT_W         = 1 << N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TT_W-1:0]   expected,
  output logic [N_IN-1:0]   stim,
  input  logic              e_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [TT_W-1:0]   mismatch_mask,
  output logic [N_IN:0]     err_count
);

  // Settle counter only has to reach SETTLE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  STIM_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [TT_W-1:0]   expected_latch;
  logic              miss;
  logic [N_IN:0]     err_count_inc;

  // Mismatch between the block's output and the latched expectation for the
  // vector currently on stim.
  assign miss          = (e_in != expected_latch[stim]);
  assign err_count_inc = err_count + (N_IN + 1)'(1);

  // Sweep sequencer: owns the state, the stimulus and all result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      expected_latch <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_mask  <= '0;
      err_count      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // start wins over a simultaneous abort here: abort means nothing
          // while idle.
          if (start) begin
            expected_latch <= expected;
            stim           <= '0;
            mismatch_mask  <= '0;
            err_count      <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end

        SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (settle_cnt == CNT_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        SAMPLE: begin
          // An abort on the sampling edge discards that sample entirely.
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (miss) begin
              mismatch_mask[stim] <= 1'b1;
              err_count           <= err_count_inc;
            end
            if (stim != STIM_LAST) begin
              stim       <= stim + N_IN'(1);
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              // stim is left at the last vector until the next start.
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !miss;
              state <= IDLE;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: a majority-function instance with default
// timing plus a SETTLE_CYCLES=1 instance run with start held high. Expected
// sweep results come from a truth-table comparison model and are queued at
// start; monitors pop and compare on every done pulse.
module tb_tt_response_checker;

  typedef struct {
    logic [7:0] mask;
    logic [3:0] err;
    logic       pass;
  } res_t;

  logic       clk;
  logic       rst_n;

  // Default-parameter instance
  logic       start, abort, e_in, busy, done, pass;
  logic [7:0] expected, mismatch_mask, dut_tbl;
  logic [2:0] stim;
  logic [3:0] err_count;

  // SETTLE_CYCLES=1 instance
  logic       start1, abort1, e_in1, busy1, done1, pass1;
  logic [7:0] expected1, mismatch_mask1;
  logic [2:0] stim1;
  logic [3:0] err_count1;

  int   total = 0;
  int   bad   = 0;
  res_t sb_q[$];
  res_t sb1_q[$];
  res_t mon_r, mon1_r;

  localparam logic [7:0] MAJ = 8'hE8;

  // The block under check is modelled as a lookup of its truth table.
  assign e_in  = dut_tbl[stim];
  assign e_in1 = MAJ[stim1];

  tt_response_checker #(.N_IN(3), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .stim(stim), .e_in(e_in), .busy(busy),
    .done(done), .pass(pass), .mismatch_mask(mismatch_mask),
    .err_count(err_count)
  );

  tt_response_checker #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .expected(expected1), .stim(stim1), .e_in(e_in1), .busy(busy1),
    .done(done1), .pass(pass1), .mismatch_mask(mismatch_mask1),
    .err_count(err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: compare the first nvec vectors of the two truth tables.
  function automatic res_t model(input logic [7:0] ex, input logic [7:0] tbl, input int nvec);
    res_t r;
    r.mask = '0;
    r.err  = '0;
    for (int i = 0; i < nvec; i++) begin
      if (ex[i] != tbl[i]) begin
        r.mask[i] = 1'b1;
        r.err     = r.err + 4'd1;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  // Monitors: judge each completed sweep against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected_done: got done=1 expected no pending sweep at %0t", $time);
      end else begin
        mon_r = sb_q.pop_front();
        chk("sb_mask", 32'(mismatch_mask), 32'(mon_r.mask));
        chk("sb_err",  32'(err_count),     32'(mon_r.err));
        chk("sb_pass", 32'(pass),          32'(mon_r.pass));
        $display("sweep done: mask=%02h err=%0d pass=%0b", mismatch_mask, err_count, pass);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (sb1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_unexpected_done: got done1=1 expected no pending sweep at %0t", $time);
      end else begin
        mon1_r = sb1_q.pop_front();
        chk("sb1_mask", 32'(mismatch_mask1), 32'(mon1_r.mask));
        chk("sb1_err",  32'(err_count1),     32'(mon1_r.err));
        chk("sb1_pass", 32'(pass1),          32'(mon1_r.pass));
        $display("sweep1 done: mask=%02h err=%0d pass=%0b", mismatch_mask1, err_count1, pass1);
      end
    end
  end

  // One sweep on the default instance. Non-zero abort_at/chg_at/rst_at give
  // the edge (counted from the start edge) of an abort, an expected change,
  // or an asynchronous reset pulse.
  task automatic run_sweep(input logic [7:0] ex, input logic [7:0] tbl,
                           input int abort_at, input int chg_at, input int rst_at);
    res_t m;
    int   walk_bad;
    int   done_cnt;
    int   exp_stim;
    logic pass_before;
    dut_tbl = tbl;
    @(negedge clk);
    expected = ex;
    start    = 1'b1;
    if (abort_at == 0 && rst_at == 0) sb_q.push_back(model(ex, tbl, 8));
    pass_before = pass;
    @(posedge clk);
    #1 start = 1'b0;
    walk_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == abort_at) abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (k == chg_at) expected = 8'h00;
      if (k == abort_at) begin
        m = model(ex, tbl, (k - 1) / 5);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err",  32'(err_count), 32'(m.err));
        chk("abort_mask", 32'(mismatch_mask), 32'(m.mask));
        chk("abort_pass_kept", 32'(pass), 32'(pass_before));
        done_cnt = 0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        return;
      end
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {19'd0, stim, busy, done, pass, mismatch_mask, err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      exp_stim = (k / 5 > 7) ? 7 : k / 5;
      if (stim !== 3'(exp_stim)) walk_bad++;
      if (k < 40) begin
        if (busy !== 1'b1 || done !== 1'b0) walk_bad++;
      end else begin
        chk("done_at_40", 32'(done), 32'd1);
        chk("busy_low_at_40", 32'(busy), 32'd0);
      end
    end
    chk("stim_walk", 32'(walk_bad), 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   walk_bad1;
    int   j;
    int   exp_stim;
    logic exp_done;
    logic [7:0] ex, tbl;

    rst_n = 1'b0; start = 0; abort = 0; expected = 0; dut_tbl = 0;
    start1 = 0; abort1 = 0; expected1 = MAJ;
    repeat (3) @(negedge clk);
    chk("reset_state", {19'd0, stim, busy, done, pass, mismatch_mask, err_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(MAJ, MAJ, 0, 0, 0);        // correct majority block
    run_sweep(MAJ, 8'h00, 0, 0, 0);      // output stuck at 0
    run_sweep(MAJ, MAJ, 0, 12, 0);       // expected changes mid-sweep
    run_sweep(MAJ, ~MAJ, 17, 0, 0);      // abort while always mismatching
    run_sweep(MAJ, MAJ, 0, 0, 22);       // async reset mid-sweep
    chk("post_reset_pass", 32'(pass), 32'd0);
    run_sweep(MAJ, MAJ, 0, 0, 0);        // clean sweep after reset
    for (int n = 0; n < 6; n++) begin
      ex  = 8'($urandom);
      tbl = ($urandom_range(0, 1) == 1) ? ex : 8'($urandom);
      run_sweep(ex, tbl, 0, 0, 0);
    end

    // SETTLE_CYCLES=1 with start held: 16-cycle sweeps, restart one edge later.
    sb1_q.push_back(model(MAJ, MAJ, 8));
    sb1_q.push_back(model(MAJ, MAJ, 8));
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    walk_bad1 = 0;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      j        = (k >= 17) ? k - 17 : k;
      exp_stim = (j / 2 > 7) ? 7 : j / 2;
      exp_done = (k == 16) || (k == 33);
      if (stim1 !== 3'(exp_stim)) walk_bad1++;
      if (done1 !== exp_done || busy1 !== !exp_done) walk_bad1++;
      if (k == 16) chk("s1_done_at_16", 32'(done1), 32'd1);
      if (k == 17) chk("s1_restart_at_17", 32'({busy1, stim1}), 32'h8);
      if (k == 33) chk("s1_done_at_33", 32'(done1), 32'd1);
    end
    chk("s1_stim_walk", 32'(walk_bad1), 32'd0);
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(negedge clk);

    chk("sb_drained", 32'(sb_q.size() + sb1_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
